system_bus_arbiter: RTL and testbench
=====================================

Name: system_bus_arbiter

Overview:
- Two-master arbiter placed in front of the single system bus slave port (ready / addr / write_data / byte_enable / write_req / read_req / read_data / read_data_valid).
- Typical masters: m0 = CPU instruction fetch, m1 = CPU load/store or a debug/loader DMA.
- Grants round-robin per accepted transaction and locks the grant while a request is stalled.
- Tracks the issuer of every outstanding read in an in-order tag FIFO, so read_data_valid is routed back to the correct master.

Parameters:
- MAX_OUTSTANDING, 4, maximum number of reads in flight; power of 2, ≥2.
- CNT_W, $clog2(MAX_OUTSTANDING)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_ready  out  1  m0 request accepted this cycle when ready && (read_req||write_req)
- m0_addr  in  30  [31:2] word address
- m0_write_data  in  32  write data
- m0_byte_enable  in  4  byte lanes
- m0_write_req  in  1  write request
- m0_read_req  in  1  read request
- m0_read_data  out  32  returned read data
- m0_read_data_valid  out  1  read data strobe for m0
- m1_*  (same seven signals as m0)
- bus_ready  in  1  system bus ready
- bus_addr  out  30  [31:2] forwarded address
- bus_write_data  out  32
- bus_byte_enable  out  4
- bus_write_req  out  1
- bus_read_req  out  1
- bus_read_data  in  32
- bus_read_data_valid  in  1
- protocol_error  out  1  sticky: bus_read_data_valid seen with no read outstanding

Behaviour:
- Request detection: m_req = read_req || write_req. Both asserted at once by one master is illegal; read takes precedence.
- Arbitration (combinational from registered state):
  - If lock=1, the grant stays on lock_owner.
  - Otherwise, only one master requesting → that master.
  - Otherwise, both requesting → the master that is not last_grant.
  - Default owner when neither requests: last_grant.
- Mux: bus_addr, bus_write_data and bus_byte_enable come from the granted master.
- bus_read_req = granted read_req && !fifo_full.
- bus_write_req = granted write_req.
- Ready outputs:
  - Granted master: m_ready = bus_ready && !(read_req && fifo_full).
  - Non-granted master: m_ready = 0.
- Acceptance: accept = granted m_req && granted m_ready. On accept, last_grant <= owner and lock <= 0.
- Stall: granted m_req && !m_ready sets lock <= 1 and lock_owner <= owner. The granted master must hold its request stable until accepted.
- Tag FIFO:
  - Depth MAX_OUTSTANDING, 1-bit entries (issuer id).
  - Push on accepted read; pop on bus_read_data_valid.
  - fifo_full = (count == MAX_OUTSTANDING).
  - While full, new reads are blocked even if a pop occurs in the same cycle.
  - Writes are never blocked by FIFO state.
- Return routing:
  - On bus_read_data_valid with a non-empty FIFO, head id selects the master: that master's read_data_valid=1, the other's =0.
  - m0_read_data and m1_read_data both always carry bus_read_data.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Latency:
  - Arbitration and forwarding: 0 cycles (combinational path request→bus).
  - Read data routing: 0 cycles (bus_read_data_valid→m_read_data_valid combinational).
  - Bus read data never returns in the issue cycle.
- Empty FIFO + bus_read_data_valid: no master strobed, count stays 0, protocol_error <= 1 (sticky until reset).
- Pointer wrap: modulo MAX_OUTSTANDING.
- Reset (async, active-low, any time including mid-stall or with reads in flight):
  - State: count=0, pointers=0, lock=0, lock_owner=0, last_grant=1 (m0 wins first tie), protocol_error=0.
  - All in-flight read tags are discarded; late returns after reset raise protocol_error.
- Outputs while reset_n=0: bus_*_req=0, m*_ready=0, m*_read_data_valid=0.

Decomposition:
- Package system_bus_pkg:
  - master_id_t (1-bit enum MASTER_0, MASTER_1).
  - Bus request struct: addr, write_data, byte_enable, write_req, read_req.
  - Constant ADDR_LSB=2.
- Sub-module read_tag_fifo: parameterised depth and width, push/pop/full/empty/count, async reset.
- Arbitration, lock and routing stay in the top module.

Test Plan:
- Both masters read back-to-back with bus_ready=1 and 2-cycle read latency → grants alternate m0,m1,m0,m1; data 0xA0,0xB1,0xA2,0xB3 strobed on m0,m1,m0,m1 valid lines in that order.
- m1 write stalled (bus_ready=0 for 3 cycles) while m0 requests → grant locked on m1; m0_ready=0 throughout; m1 accepted in cycle 4; m0 granted in cycle 5.
- m0 issues 4 reads with no return → 5th read sees m0_ready=0 and bus_read_req=0. A concurrent m1 write is granted and accepted. One bus_read_data_valid pulse → m0 read accepted the following cycle.
- Same-cycle accept and return with count=2 → count stays 2; head tag is popped and routed correctly; new tag is enqueued at tail.
- bus_read_data_valid pulse with count=0 → no m*_read_data_valid; protocol_error=1 and remains 1 until reset_n=0.
- reset_n asserted asynchronously with 3 reads outstanding and lock=1 → all outputs idle immediately, count=0. After release, first tie goes to m0.

Source files
------------

// File: rtl/system_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_pkg
// Description : Shared types and constants for the two-master system bus
//               arbiter (master ids, bundled request struct, bus widths).
// Revision    : 1.0 - initial release
// ============================================================================
package system_bus_pkg;

  // Word-addressed bus: byte offset bits are not carried on the address lines.
  localparam int ADDR_LSB = 2;
  localparam int ADDR_W   = 32 - ADDR_LSB;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;

  typedef enum logic [0:0] {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_id_t;

  // Everything a master presents on the request side, muxed as one unit.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [BE_W-1:0]   byte_enable;
    logic              write_req;
    logic              read_req;
  } bus_req_t;

  function automatic master_id_t other_master(input master_id_t id);
    return (id == MASTER_0) ? MASTER_1 : MASTER_0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/system_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_arbiter_if
// Description : Simple system bus handshake (ready / request / read return).
//               The master modport issues requests, the slave modport
//               accepts them and returns read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface system_bus_arbiter_if;
  import system_bus_pkg::*;

  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   byte_enable;
  logic              write_req;
  logic              read_req;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;

  modport master (
    input  ready, read_data, read_data_valid,
    output addr, write_data, byte_enable, write_req, read_req
  );

  modport slave (
    output ready, read_data, read_data_valid,
    input  addr, write_data, byte_enable, write_req, read_req
  );

endinterface
`default_nettype wire

// File: rtl/system_bus_arbiter_read_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : read_tag_fifo
// Description : Small in-order FIFO holding the issuer id of each read in
//               flight. Push is ignored when full, pop is ignored when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module read_tag_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/system_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_arbiter
// Description : Two-master round-robin arbiter in front of one system bus
//               slave port. The grant is held while a request stalls, and
//               read returns are routed via an in-order issuer tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module system_bus_arbiter
  import system_bus_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  system_bus_arbiter_if.slave   m0,
  system_bus_arbiter_if.slave   m1,
  system_bus_arbiter_if.master  bus,
  output logic                  protocol_error
);

  bus_req_t   w_m0_req;
  bus_req_t   w_m1_req;
  bus_req_t   w_gnt_req;
  logic       w_m0_any;
  logic       w_m1_any;
  master_id_t w_owner;
  logic [0:0] w_owner_tag;
  logic       w_gnt_any;
  logic       w_gnt_read;
  logic       w_gnt_write;
  logic       w_gnt_ready;
  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [0:0] w_head_tag;
  master_id_t w_head;

  logic       r_lock;
  master_id_t r_lock_owner;
  master_id_t r_last_grant;

  assign w_m0_req = '{addr: m0.addr, write_data: m0.write_data, byte_enable: m0.byte_enable,
                      write_req: m0.write_req, read_req: m0.read_req};
  assign w_m1_req = '{addr: m1.addr, write_data: m1.write_data, byte_enable: m1.byte_enable,
                      write_req: m1.write_req, read_req: m1.read_req};
  assign w_m0_any = w_m0_req.read_req || w_m0_req.write_req;
  assign w_m1_any = w_m1_req.read_req || w_m1_req.write_req;

  // Grant selection: a stalled owner keeps the bus, otherwise round-robin.
  always_comb begin
    w_owner = r_last_grant;
    if (r_lock) begin
      w_owner = r_lock_owner;
    end else if (w_m0_any && !w_m1_any) begin
      w_owner = MASTER_0;
    end else if (w_m1_any && !w_m0_any) begin
      w_owner = MASTER_1;
    end else if (w_m0_any && w_m1_any) begin
      w_owner = other_master(r_last_grant);
    end
  end

  assign w_gnt_req   = (w_owner == MASTER_1) ? w_m1_req : w_m0_req;
  assign w_gnt_any   = w_gnt_req.read_req || w_gnt_req.write_req;
  assign w_gnt_read  = w_gnt_req.read_req;
  // A master asserting both strobes is treated as reading.
  assign w_gnt_write = w_gnt_req.write_req && !w_gnt_req.read_req;
  // A full tag FIFO blocks reads even if a tag retires this same cycle.
  assign w_gnt_ready = reset_n && bus.ready && !(w_gnt_read && w_fifo_full);
  assign w_accept    = w_gnt_any && w_gnt_ready;
  assign w_push      = w_accept && w_gnt_read;
  assign w_pop       = bus.read_data_valid && !w_fifo_empty;
  assign w_owner_tag = w_owner;
  assign w_head      = master_id_t'(w_head_tag);

  assign bus.addr        = w_gnt_req.addr;
  assign bus.write_data  = w_gnt_req.write_data;
  assign bus.byte_enable = w_gnt_req.byte_enable;
  assign bus.read_req    = reset_n && w_gnt_read && !w_fifo_full;
  assign bus.write_req   = reset_n && w_gnt_write;

  assign m0.ready           = (w_owner == MASTER_0) && w_gnt_ready;
  assign m1.ready           = (w_owner == MASTER_1) && w_gnt_ready;
  assign m0.read_data       = bus.read_data;
  assign m1.read_data       = bus.read_data;
  assign m0.read_data_valid = reset_n && w_pop && (w_head == MASTER_0);
  assign m1.read_data_valid = reset_n && w_pop && (w_head == MASTER_1);

  read_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_owner_tag),
    .pop       (w_pop),
    .pop_data  (w_head_tag),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  // Round-robin history and stall lock; MASTER_1 as last grant lets m0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock       <= 1'b0;
      r_lock_owner <= MASTER_0;
      r_last_grant <= MASTER_1;
    end else if (w_accept) begin
      r_last_grant <= w_owner;
      r_lock       <= 1'b0;
    end else if (w_gnt_any) begin
      r_lock       <= 1'b1;
      r_lock_owner <= w_owner;
    end
  end

  // Sticky flag for a read return arriving with no read in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protocol_error <= 1'b0;
    end else if (bus.read_data_valid && (w_fifo_count == '0)) begin
      protocol_error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_system_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_system_bus_arbiter
// Description : Self-checking bench: directed vector table, hand-written
//               corner sequences and a randomized run against a queue-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_system_bus_arbiter;
  import system_bus_pkg::*;

  localparam int MAXO = 4;
  localparam logic [29:0] A0 = 30'h100;
  localparam logic [29:0] A1 = 30'h200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic protocol_error;

  always #5 clk = ~clk;

  system_bus_arbiter_if m0_if ();
  system_bus_arbiter_if m1_if ();
  system_bus_arbiter_if bus_if ();

  system_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .bus            (bus_if),
    .protocol_error (protocol_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r0, input bit w0, input bit r1, input bit w1,
                       input bit rdy, input bit rdv, input logic [31:0] rdat);
    m0_if.read_req = r0; m0_if.write_req = w0; m0_if.addr = A0;
    m0_if.write_data = 32'h0000_00C0; m0_if.byte_enable = 4'hF;
    m1_if.read_req = r1; m1_if.write_req = w1; m1_if.addr = A1;
    m1_if.write_data = 32'h0000_00C1; m1_if.byte_enable = 4'h3;
    bus_if.ready = rdy; bus_if.read_data_valid = rdv; bus_if.read_data = rdat;
  endtask

  task automatic chk_bus(input string t, input bit brd, input bit bwr, input bit r0, input bit r1);
    check({t, ".bus_rd"}, 32'(bus_if.read_req), 32'(brd));
    check({t, ".bus_wr"}, 32'(bus_if.write_req), 32'(bwr));
    check({t, ".m0_rdy"}, 32'(m0_if.ready), 32'(r0));
    check({t, ".m1_rdy"}, 32'(m1_if.ready), 32'(r1));
  endtask

  task automatic chk_valid(input string t, input bit v0, input bit v1);
    check({t, ".m0_v"}, 32'(m0_if.read_data_valid), 32'(v0));
    check({t, ".m1_v"}, 32'(m1_if.read_data_valid), 32'(v1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit m0_rd; bit m1_rd; bit rdy; bit rdv; logic [31:0] rdata;
    bit e_rd; logic [29:0] e_addr; bit e_r0; bit e_r1; bit e_v0; bit e_v1;
  } vec_t;

  vec_t vt[6];

  // Reference model state for the random phase
  bit          q[$];
  bit          mlock;
  int          mlown;
  int          mlast;
  bit          mperr;
  bit          rd[2];
  bit          wr[2];
  logic [29:0] ad[2];
  logic [31:0] wd[2];
  logic [3:0]  be[2];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Back-to-back reads from both masters, two-cycle read latency
    vt[0] = '{1, 1, 1, 0, 32'h0,  1, A0, 1, 0, 0, 0};
    vt[1] = '{1, 1, 1, 0, 32'h0,  1, A1, 0, 1, 0, 0};
    vt[2] = '{1, 1, 1, 1, 32'hA0, 1, A0, 1, 0, 1, 0};
    vt[3] = '{1, 1, 1, 1, 32'hB1, 1, A1, 0, 1, 0, 1};
    vt[4] = '{0, 0, 1, 1, 32'hA2, 0, A1, 0, 1, 1, 0};
    vt[5] = '{0, 0, 1, 1, 32'hB3, 0, A1, 0, 1, 0, 1};

    // Outputs are gated while reset is held, even with requests present
    drive(1, 0, 1, 0, 1, 1, 32'h0);
    #2;
    chk_bus("rst", 0, 0, 0, 0);
    chk_valid("rst", 0, 0);
    check("rst.perr", 32'(protocol_error), 32'd0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vt[i].m0_rd, 0, vt[i].m1_rd, 0, vt[i].rdy, vt[i].rdv, vt[i].rdata);
      #1;
      chk_bus($sformatf("rr[%0d]", i), vt[i].e_rd, 0, vt[i].e_r0, vt[i].e_r1);
      check($sformatf("rr[%0d].addr", i), 32'(bus_if.addr), 32'(vt[i].e_addr));
      chk_valid($sformatf("rr[%0d]", i), vt[i].e_v0, vt[i].e_v1);
      check($sformatf("rr[%0d].m1_data", i), m1_if.read_data, vt[i].rdata);
    end

    // Stalled m1 write keeps the grant while m0 waits
    do_reset();
    @(negedge clk); drive(0, 0, 0, 1, 0, 0, 32'h0); #1;
    chk_bus("stall1", 0, 1, 0, 0);
    check("stall1.addr", 32'(bus_if.addr), 32'(A1));
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk); drive(1, 0, 0, 1, 0, 0, 32'h0); #1;
      chk_bus($sformatf("stall%0d", i), 0, 1, 0, 0);
      check($sformatf("stall%0d.addr", i), 32'(bus_if.addr), 32'(A1));
    end
    @(negedge clk); drive(1, 0, 0, 1, 1, 0, 32'h0); #1;
    chk_bus("stall4", 0, 1, 0, 1);
    check("stall4.wdata", bus_if.write_data, 32'h0000_00C1);
    @(negedge clk); drive(1, 0, 0, 0, 1, 0, 32'h0); #1;
    chk_bus("stall5", 1, 0, 1, 0);
    check("stall5.addr", 32'(bus_if.addr), 32'(A0));

    // Tag FIFO full: reads blocked, writes still flow
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1, 0, 0, 0, 1, 0, 32'h0); #1;
      chk_bus($sformatf("full.rd%0d", i), 1, 0, 1, 0);
    end
    @(negedge clk); drive(1, 0, 0, 1, 1, 0, 32'h0); #1;
    chk_bus("full.wr", 0, 1, 0, 1);
    @(negedge clk); drive(1, 0, 0, 0, 1, 0, 32'h0); #1;
    chk_bus("full.blk", 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 1, 1, 32'h55); #1;
    chk_bus("full.pop", 0, 0, 0, 0);
    chk_valid("full.pop", 1, 0);
    @(negedge clk); drive(1, 0, 0, 0, 1, 0, 32'h0); #1;
    chk_bus("full.after", 1, 0, 1, 0);

    // Return with nothing outstanding raises a sticky error
    do_reset();
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 32'h77); #1;
    chk_valid("perr", 0, 0);
    check("perr.pre", 32'(protocol_error), 32'd0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 0, 32'h0); #1;
    check("perr.set", 32'(protocol_error), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("perr.sticky", 32'(protocol_error), 32'd1);
    reset_n = 1'b0; #1;
    check("perr.clr", 32'(protocol_error), 32'd0);
    reset_n = 1'b1;

    // Async reset with reads in flight and grant locked
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1, 0, 0, 0, 1, 0, 32'h0);
    end
    @(negedge clk); drive(0, 0, 0, 1, 0, 0, 32'h0);
    @(negedge clk); drive(1, 0, 0, 1, 0, 0, 32'h0);
    #1;
    chk_bus("arst.pre", 0, 1, 0, 0);
    #1; reset_n = 1'b0; #1;
    chk_bus("arst", 0, 0, 0, 0);
    bus_if.read_data_valid = 1'b1; #1;
    chk_valid("arst", 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 32'h9); reset_n = 1'b1; #1;
    chk_valid("arst.late", 0, 0);
    @(negedge clk); drive(1, 0, 1, 0, 1, 0, 32'h0); #1;
    check("arst.perr", 32'(protocol_error), 32'd1);
    chk_bus("arst.tie", 1, 0, 1, 0);
    check("arst.addr", 32'(bus_if.addr), 32'(A0));

    // Randomized run against the queue-based reference model
    do_reset();
    q.delete();
    mlock = 0; mlown = 0; mlast = 1; mperr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int own;
      bit full, greq, grdy, rdyv, rdv, ev0, ev1;
      logic [31:0] rdat;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!(mlock && mlown == m)) begin
          int r;
          r = $urandom_range(0, 9);
          rd[m] = (r < 3);
          wr[m] = (r >= 3 && r < 6);
          ad[m] = 30'($urandom);
          wd[m] = $urandom;
          be[m] = 4'($urandom);
        end
      end
      rdyv = ($urandom_range(0, 3) != 0);
      rdv  = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
      rdat = $urandom;
      m0_if.read_req = rd[0]; m0_if.write_req = wr[0]; m0_if.addr = ad[0];
      m0_if.write_data = wd[0]; m0_if.byte_enable = be[0];
      m1_if.read_req = rd[1]; m1_if.write_req = wr[1]; m1_if.addr = ad[1];
      m1_if.write_data = wd[1]; m1_if.byte_enable = be[1];
      bus_if.ready = rdyv; bus_if.read_data_valid = rdv; bus_if.read_data = rdat;

      if (mlock) own = mlown;
      else if ((rd[0] | wr[0]) && (rd[1] | wr[1])) own = 1 - mlast;
      else if (rd[0] | wr[0]) own = 0;
      else if (rd[1] | wr[1]) own = 1;
      else own = mlast;
      full = (q.size() == MAXO);
      greq = rd[own] | wr[own];
      grdy = rdyv && !(rd[own] && full);
      ev0  = rdv && (q.size() > 0) && (q[0] == 1'b0);
      ev1  = rdv && (q.size() > 0) && (q[0] == 1'b1);

      #1;
      chk_bus($sformatf("rnd[%0d]", cyc), rd[own] && !full, wr[own] && !rd[own],
              (own == 0) && grdy, (own == 1) && grdy);
      check($sformatf("rnd[%0d].addr", cyc), 32'(bus_if.addr), 32'(ad[own]));
      check($sformatf("rnd[%0d].wdata", cyc), bus_if.write_data, wd[own]);
      check($sformatf("rnd[%0d].be", cyc), 32'(bus_if.byte_enable), 32'(be[own]));
      chk_valid($sformatf("rnd[%0d]", cyc), ev0, ev1);
      check($sformatf("rnd[%0d].m0_data", cyc), m0_if.read_data, rdat);
      check($sformatf("rnd[%0d].perr", cyc), 32'(protocol_error), 32'(mperr));

      @(posedge clk);
      if (rdv) begin
        if (q.size() > 0) void'(q.pop_front());
        else mperr = 1'b1;
      end
      if (greq && grdy) begin
        if (rd[own]) q.push_back(own[0]);
        mlast = own;
        mlock = 1'b0;
      end else if (greq) begin
        mlock = 1'b1;
        mlown = own;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
